divisor_sequencial: RTL and testbench
=====================================

// Module: divisor_sequencial
// PURPOSE
//  Unsigned restoring divider: one quotient bit per clock, N cycles per operation.
//  Inverse operation of the board's 5-bit ripple adder, on the same switch/key/LED I/O.
//  Operands come from SW; a KEY[0] press starts the division.
//  Quotient, remainder and status are shown on LEDR/LEDG.
// PARAMETERS
//  N     5   operand width; dividend = SW[N-1:0], divisor = SW[2N-1:N]
// PORTS
//  CLOCK_50  in   1     single system clock, all state on rising edge
//  KEY[1]    in   1     reset: asynchronous, active-low; clears all state immediately
//  KEY[0]    in   1     start pushbutton, active-low, asynchronous to CLOCK_50
//  SW        in   2N    {divisor, dividend}, sampled only in LOAD
//  LEDR      out  2N    {remainder, quotient}, registered
//  LEDG      out  3     {div_zero, done, busy}, registered
// BEHAVIOUR
//  Reset (KEY[1]=0, any time incl. mid-operation):
//   state=IDLE; LEDR=0; LEDG=0; sync flops=1 (released button); A, Q, M regs=0.
//  Start detect:
//   - KEY[0] passes through a 2-flop synchronizer.
//   - start_pulse = 1-cycle pulse on the synchronized 1->0 edge.
//   - A held button gives one pulse only.
//  FSM states: IDLE, LOAD, DIVIDE, DONE.
//   IDLE  : start_pulse -> LOAD.
//   LOAD  : Q<=dividend, M<=divisor, A<=0 (N+1 bits), cnt<=N-1; busy=1, done=0, div_zero=0.
//           divisor==0 -> DONE with LEDR={dividend, {N{1'b1}}}, div_zero=1.
//           otherwise -> DIVIDE.
//   DIVIDE: {A,Q} shifted left 1; D = A_shifted - {0,M} (N+1-bit ripple subtract).
//           D[N]==0 : A<=D, Q[0]<=1.   D[N]==1 : A keeps shifted value, Q[0]<=0.
//           cnt==0 -> DONE, else cnt<=cnt-1.
//   DONE  : LEDR={A[N-1:0], Q} written on entry, held until next LOAD.
//           busy=0, done=1. start_pulse -> LOAD.
//  Latency: start_pulse at edge t -> LOAD at t+1 -> N DIVIDE cycles.
//   Results and done valid at edge t+N+2; divide-by-zero case at t+2.
//  start_pulse during LOAD/DIVIDE is ignored: no restart, no queueing.
//  LEDR is not cleared at the next start; it changes only on DONE entry (or reset).
//  SW changes after LOAD do not affect a running operation.
//  Width rules: A is N+1 bits so the borrow is observable; invariants r < M and q*M + r = dividend.
// STRUCTURE
//  Shared package/include: N default; state encodings IDLE=2'd0, LOAD=2'd1, DIVIDE=2'd2, DONE=2'd3.
//  Sub-module subtrator_ripple #(W):
//   - W-bit borrow-ripple subtractor built from subtrator_completo cells:
//     d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
//   - Ports: a, b, diff, bout.
//   - Instantiated once with W=N+1.
//  Top holds the synchronizer, edge detect, FSM, counter, A/Q/M registers and output registers.
// TESTING
//  1 SW={5'd5,5'd23}, press KEY[0] -> after N+2 cycles LEDR={5'd3,5'd4}, LEDG=3'b010.
//  2 SW={5'd1,5'd31}, press -> LEDR={5'd0,5'd31}; SW={5'd9,5'd3} -> LEDR={5'd3,5'd0}.
//  3 SW={5'd0,5'd7}, press -> 2 cycles later LEDR={5'd7,5'd31}, LEDG=3'b110.
//  4 Second press at 2nd DIVIDE cycle of 23/5 -> ignored; still done at t+7 with q=4 r=3.
//    KEY[0] held 100 cycles -> exactly one operation.
//  5 KEY[1]=0 during DIVIDE, asynchronous to clock -> LEDR=0, LEDG=0 immediately.
//    After release the FSM is idle until the next press.
//  6 Exhaustive: all 1024 SW values, each checked against q=a/b, r=a%b (div_zero when b=0).

Source files
------------

// File: rtl/divisor_sequencial_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and LEDG status patterns.
package divisor_sequencial_pkg;

  localparam int unsigned NDefault = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StDivide = 2'd2,
    StDone   = 2'd3
  } state_e;

  // LEDG = {div_zero, done, busy}
  localparam logic [2:0] LedgBusy    = 3'b001;
  localparam logic [2:0] LedgDone    = 3'b010;
  localparam logic [2:0] LedgDivZero = 3'b110;

endpackage

// File: rtl/subtrator_completo.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_ripple.sv
// W-bit borrow-ripple subtractor (diff = a - b) built from full subtractor cells.
module subtrator_ripple #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] borrow;

  assign borrow[0] = 1'b0;
  assign bout      = borrow[W];

  for (genvar i = 0; i < W; i++) begin : g_cell
    subtrator_completo u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .bin (borrow[i]),
      .d   (diff[i]),
      .bout(borrow[i+1])
    );
  end

endmodule

// File: rtl/divisor_sequencial.sv
// Unsigned restoring divider driven from board switches/keys: one quotient bit per clock,
// results shown as {remainder, quotient} on LEDR and {div_zero, done, busy} on LEDG.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic           CLOCK_50,
  input  logic [1:0]     KEY,
  input  logic [2*N-1:0] SW,
  output logic [2*N-1:0] LEDR,
  output logic [2:0]     LEDG
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic rst_n;
  assign rst_n = KEY[1];

  // KEY[0] synchronizer plus one extra stage for falling-edge detection
  logic key_s1_q, key_s2_q, key_s3_q;
  logic start_pulse;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_s3_q <= 1'b1;
    end else begin
      key_s1_q <= KEY[0];
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
    end
  end

  assign start_pulse = key_s3_q & ~key_s2_q;

  state_e         state_q, state_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   m_q, m_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] ledr_q, ledr_d;
  logic [2:0]     ledg_q, ledg_d;

  logic [N:0]   a_sh;
  logic [N:0]   sub_d;
  logic         sub_bout;
  logic [N-1:0] q_sh;

  assign a_sh = {a_q[N-1:0], q_q[N-1]};
  assign q_sh = q_q << 1;

  subtrator_ripple #(
    .W(N + 1)
  ) u_sub (
    .a   (a_sh),
    .b   ({1'b0, m_q}),
    .diff(sub_d),
    .bout(sub_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_pulse) begin
          state_d = StLoad;
          ledg_d  = LedgBusy;
        end
      end
      StLoad: begin
        q_d   = SW[N-1:0];
        m_d   = SW[2*N-1:N];
        a_d   = '0;
        cnt_d = CntW'(N - 1);
        if (SW[2*N-1:N] == '0) begin
          state_d = StDone;
          ledr_d  = {SW[N-1:0], {N{1'b1}}};
          ledg_d  = LedgDivZero;
        end else begin
          state_d = StDivide;
          ledg_d  = LedgBusy;
        end
      end
      StDivide: begin
        // Since A < M always holds, the borrow-out equals D[N] (negative trial result)
        a_d = sub_bout ? a_sh : sub_d;
        q_d = {q_sh[N-1:1], ~sub_bout};
        if (cnt_q == '0) begin
          state_d = StDone;
          ledr_d  = {a_d[N-1:0], q_d};
          ledg_d  = LedgDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
    end
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed and exhaustive checks of divisor_sequencial (N=5) on its board-style I/O.
module tb_divisor_sequencial;

  logic       CLOCK_50 = 1'b0;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [2:0] LEDG;

  int checks = 0;
  int passes = 0;
  logic [9:0] prev_ledr = '0;

  // Edges from press to result: 2 synchronizer edges, LOAD entry, LOAD, 5 DIVIDE
  localparam int LatNorm = 9;
  localparam int LatZero = 4;

  divisor_sequencial #(.N(5)) dut (
    .CLOCK_50(CLOCK_50),
    .KEY     (KEY),
    .SW      (SW),
    .LEDR    (LEDR),
    .LEDG    (LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [9:0] sw);
    @(negedge CLOCK_50);
    SW     = sw;
    KEY[0] = 1'b0;
  endtask

  task automatic release_key();
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    KEY = 2'b01;
    SW  = '0;
    tick(3);
    checks++;
    if ({LEDR, LEDG} !== 13'd0) $display("FAIL reset_hold: got %h/%b expected 0/000", LEDR, LEDG);
    else passes++;
    @(negedge CLOCK_50);
    KEY[1] = 1'b1;
    tick(5);
    checks++;
    if ({LEDR, LEDG} !== 13'd0) $display("FAIL reset_idle: got %h/%b expected 0/000", LEDR, LEDG);
    else passes++;
  endtask

  task automatic test_basic();
    logic [9:0] sw_t [3];
    logic [9:0] exp_t[3];
    sw_t  = '{{5'd5, 5'd23}, {5'd1, 5'd31}, {5'd9, 5'd3}};
    exp_t = '{{5'd3, 5'd4}, {5'd0, 5'd31}, {5'd3, 5'd0}};
    for (int i = 0; i < 3; i++) begin
      press(sw_t[i]);
      tick(LatNorm - 1);
      checks++;
      if (LEDG !== 3'b001 || LEDR !== prev_ledr)
        $display("FAIL basic_busy[%0d]: got %h/%b expected %h/001", i, LEDR, LEDG, prev_ledr);
      else passes++;
      tick(1);
      checks++;
      if (LEDR !== exp_t[i] || LEDG !== 3'b010)
        $display("FAIL basic_done[%0d]: got %h/%b expected %h/010", i, LEDR, LEDG, exp_t[i]);
      else passes++;
      prev_ledr = exp_t[i];
      release_key();
    end
  endtask

  task automatic test_div_zero();
    press({5'd0, 5'd7});
    tick(LatZero - 1);
    checks++;
    if (LEDG !== 3'b001 || LEDR !== prev_ledr)
      $display("FAIL divzero_busy: got %h/%b expected %h/001", LEDR, LEDG, prev_ledr);
    else passes++;
    tick(1);
    checks++;
    if (LEDR !== {5'd7, 5'd31} || LEDG !== 3'b110)
      $display("FAIL divzero_done: got %h/%b expected %h/110", LEDR, LEDG, {5'd7, 5'd31});
    else passes++;
    release_key();
  endtask

  task automatic test_ignore_restart();
    press({5'd5, 5'd23});
    tick(2);
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    tick(2);
    // second press lands mid-DIVIDE; SW also changes under the running operation
    press(10'h3FF);
    tick(5);
    checks++;
    if (LEDR !== {5'd3, 5'd4} || LEDG !== 3'b010)
      $display("FAIL ignore_done: got %h/%b expected %h/010", LEDR, LEDG, {5'd3, 5'd4});
    else passes++;
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    tick(12);
    checks++;
    if (LEDR !== {5'd3, 5'd4} || LEDG !== 3'b010)
      $display("FAIL ignore_norestart: got %h/%b expected %h/010", LEDR, LEDG, {5'd3, 5'd4});
    else passes++;
  endtask

  task automatic test_held_button();
    int busy_cnt;
    busy_cnt = 0;
    press({5'd9, 5'd3});
    tick(LatNorm);
    checks++;
    if (LEDR !== {5'd3, 5'd0} || LEDG !== 3'b010)
      $display("FAIL held_done: got %h/%b expected %h/010", LEDR, LEDG, {5'd3, 5'd0});
    else passes++;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (LEDG[0] === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== 0) $display("FAIL held_single: got %0d busy cycles expected 0", busy_cnt);
    else passes++;
    release_key();
  endtask

  task automatic test_async_reset();
    press({5'd1, 5'd31});
    tick(5);
    #2;
    KEY = 2'b00;
    #1;
    checks++;
    if ({LEDR, LEDG} !== 13'd0)
      $display("FAIL async_reset: got %h/%b expected 0/000", LEDR, LEDG);
    else passes++;
    KEY[0] = 1'b1;
    @(negedge CLOCK_50);
    KEY[1] = 1'b1;
    tick(15);
    checks++;
    if ({LEDR, LEDG} !== 13'd0)
      $display("FAIL reset_then_idle: got %h/%b expected 0/000", LEDR, LEDG);
    else passes++;
  endtask

  task automatic test_exhaustive();
    logic [4:0] a, b;
    logic [9:0] exp_ledr;
    logic [2:0] exp_ledg;
    int         lat;
    for (int s = 0; s < 1024; s++) begin
      a = s[4:0];
      b = s[9:5];
      if (b == 5'd0) begin
        exp_ledr = {a, 5'd31};
        exp_ledg = 3'b110;
        lat      = LatZero;
      end else begin
        exp_ledr = {a % b, a / b};
        exp_ledg = 3'b010;
        lat      = LatNorm;
      end
      press(s[9:0]);
      tick(lat - 1);
      checks++;
      if (LEDG !== 3'b001) $display("FAIL exh_busy a=%0d b=%0d: got %b expected 001", a, b, LEDG);
      else passes++;
      tick(1);
      checks++;
      if (LEDR !== exp_ledr || LEDG !== exp_ledg)
        $display("FAIL exh_done a=%0d b=%0d: got %h/%b expected %h/%b",
                 a, b, LEDR, LEDG, exp_ledr, exp_ledg);
      else passes++;
      release_key();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_restart();
    test_held_button();
    test_async_reset();
    test_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
